// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_controller
//  Description : Per-frame game sequencer owning phase, lives, scroll speed
//                and crash/respawn timing; gates the player controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_flow_controller #(
    parameter int LIVES_INIT     = 3,
    parameter int CRASH_FRAMES   = 90,
    parameter int RESPAWN_FRAMES = 60,
    parameter int MAX_SPEED      = 8,
    parameter int ACCEL_FRAMES   = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       frame_start,
    input  logic       start_is_pressed,
    input  logic       accel_is_pressed,
    input  logic       collision,
    input  logic       fuel_empty,
    output logic [2:0] game_state,
    output logic       player_enable,
    output logic [3:0] scroll_speed,
    output logic [1:0] lives,
    output logic       respawn_pulse
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PLAY      = 3'd1;
    localparam logic [2:0] c_CRASH     = 3'd2;
    localparam logic [2:0] c_RESPAWN   = 3'd3;
    localparam logic [2:0] c_GAME_OVER = 3'd4;

    localparam logic [1:0] c_LIVES_INIT   = 2'(LIVES_INIT);
    localparam logic [3:0] c_MAX_SPEED    = 4'(MAX_SPEED);
    localparam logic [7:0] c_CRASH_LAST   = 8'(CRASH_FRAMES - 1);
    localparam logic [7:0] c_RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] c_ACCEL_LAST   = 8'(ACCEL_FRAMES - 1);

    logic [2:0] r_state;
    logic [3:0] r_speed;
    logic [1:0] r_lives;
    logic [7:0] r_timer;
    logic [7:0] r_accel_cnt;
    logic       r_pulse;
    logic       r_player_enable;
    logic       r_start_prev;
    logic       r_coll_latch;

    logic [2:0] w_state_nx;
    logic [3:0] w_speed_nx;
    logic [1:0] w_lives_nx;
    logic [7:0] w_timer_nx;
    logic [7:0] w_accel_nx;
    logic       w_pulse_nx;
    logic       w_press;
    logic       w_hit;

    assign w_press = frame_start & start_is_pressed & ~r_start_prev;
    // A hit arriving on the frame_start cycle itself is honoured immediately.
    assign w_hit   = r_coll_latch | collision;

    always_comb begin
        w_state_nx = r_state;
        w_speed_nx = r_speed;
        w_lives_nx = r_lives;
        w_timer_nx = r_timer;
        w_accel_nx = r_accel_cnt;
        w_pulse_nx = 1'b0;
        if (frame_start) begin
            case (r_state)
                c_IDLE: begin
                    if (w_press) begin
                        w_state_nx = c_PLAY;
                        w_lives_nx = c_LIVES_INIT;
                        w_speed_nx = 4'd0;
                        w_accel_nx = 8'd0;
                        w_pulse_nx = 1'b1;
                    end
                end
                c_PLAY: begin
                    if (fuel_empty) begin
                        w_state_nx = c_GAME_OVER;
                        w_speed_nx = 4'd0;
                    end else if (w_hit) begin
                        w_state_nx = c_CRASH;
                        w_speed_nx = 4'd0;
                        w_lives_nx = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                        w_timer_nx = c_CRASH_LAST;
                        w_accel_nx = 8'd0;
                    end else if (accel_is_pressed) begin
                        if (r_accel_cnt == c_ACCEL_LAST) begin
                            w_accel_nx = 8'd0;
                            w_speed_nx = (r_speed < c_MAX_SPEED) ? r_speed + 4'd1 : c_MAX_SPEED;
                        end else begin
                            w_accel_nx = r_accel_cnt + 8'd1;
                        end
                    end else begin
                        w_accel_nx = 8'd0;
                        w_speed_nx = (r_speed == 4'd0) ? 4'd0 : r_speed - 4'd1;
                    end
                end
                c_CRASH: begin
                    w_speed_nx = 4'd0;
                    if (r_timer == 8'd0) begin
                        if (r_lives == 2'd0) begin
                            w_state_nx = c_GAME_OVER;
                        end else begin
                            w_state_nx = c_RESPAWN;
                            w_timer_nx = c_RESPAWN_LAST;
                            w_pulse_nx = 1'b1;
                        end
                    end else begin
                        w_timer_nx = r_timer - 8'd1;
                    end
                end
                c_RESPAWN: begin
                    w_speed_nx = 4'd0;
                    if (r_timer == 8'd0) begin
                        w_state_nx = c_PLAY;
                        w_accel_nx = 8'd0;
                    end else begin
                        w_timer_nx = r_timer - 8'd1;
                    end
                end
                c_GAME_OVER: begin
                    if (w_press) begin
                        w_state_nx = c_IDLE;
                        w_lives_nx = c_LIVES_INIT;
                    end
                end
                default: begin
                    w_state_nx = c_IDLE;
                    w_speed_nx = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state         <= c_IDLE;
            r_speed         <= 4'd0;
            r_lives         <= c_LIVES_INIT;
            r_timer         <= 8'd0;
            r_accel_cnt     <= 8'd0;
            r_pulse         <= 1'b0;
            r_player_enable <= 1'b0;
            r_start_prev    <= 1'b0;
            r_coll_latch    <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_speed         <= w_speed_nx;
            r_lives         <= w_lives_nx;
            r_timer         <= w_timer_nx;
            r_accel_cnt     <= w_accel_nx;
            r_pulse         <= w_pulse_nx;
            r_player_enable <= (w_state_nx == c_PLAY);
            if (frame_start) begin
                r_start_prev <= start_is_pressed;
            end
            // Latch is consumed by every frame_start; only PLAY can arm it.
            if (frame_start) begin
                r_coll_latch <= 1'b0;
            end else if (r_state == c_PLAY && collision) begin
                r_coll_latch <= 1'b1;
            end
        end
    end

    assign game_state    = r_state;
    assign player_enable = r_player_enable;
    assign scroll_speed  = r_speed;
    assign lives         = r_lives;
    assign respawn_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_controller
//  Description : Directed self-checking bench for game_flow_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_controller;

    logic       clk;
    logic       resetN;
    logic       frame_start;
    logic       start_is_pressed;
    logic       accel_is_pressed;
    logic       collision;
    logic       fuel_empty;
    logic [2:0] game_state;
    logic       player_enable;
    logic [3:0] scroll_speed;
    logic [1:0] lives;
    logic       respawn_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    game_flow_controller #(
        .LIVES_INIT    (3),
        .CRASH_FRAMES  (90),
        .RESPAWN_FRAMES(60),
        .MAX_SPEED     (8),
        .ACCEL_FRAMES  (16)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .frame_start     (frame_start),
        .start_is_pressed(start_is_pressed),
        .accel_is_pressed(accel_is_pressed),
        .collision       (collision),
        .fuel_empty      (fuel_empty),
        .game_state      (game_state),
        .player_enable   (player_enable),
        .scroll_speed    (scroll_speed),
        .lives           (lives),
        .respawn_pulse   (respawn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n back-to-back frame_start cycles; returns on the negedge after the last one
    task automatic do_frames(input int n);
        @(negedge clk);
        frame_start = 1'b1;
        repeat (n) @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", game_state); end
        n_checks++; if (player_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %0b exp 0", player_enable); end
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL reset_speed got %0d exp 0", scroll_speed); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got %0d exp 3", lives); end
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b exp 0", respawn_pulse); end
        resetN = 1'b1;
    endtask

    task automatic test_start();
        do_frames(1);
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL idle_no_press got %0d exp 0", game_state); end
        start_is_pressed = 1'b1;
        do_frames(1);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL start_state got %0d exp 1", game_state); end
        n_checks++; if (player_enable !== 1'b1) begin n_fail++; $display("FAIL start_enable got %0b exp 1", player_enable); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL start_lives got %0d exp 3", lives); end
        n_checks++; if (respawn_pulse !== 1'b1) begin n_fail++; $display("FAIL start_pulse got %0b exp 1", respawn_pulse); end
        @(negedge clk);
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got %0b exp 0", respawn_pulse); end
        start_is_pressed = 1'b0;
        do_frames(1);
    endtask

    task automatic test_accel();
        accel_is_pressed = 1'b1;
        do_frames(31);
        n_checks++; if (scroll_speed !== 4'd1) begin n_fail++; $display("FAIL accel_31 got %0d exp 1", scroll_speed); end
        do_frames(1);
        n_checks++; if (scroll_speed !== 4'd2) begin n_fail++; $display("FAIL accel_32 got %0d exp 2", scroll_speed); end
        do_frames(200);
        n_checks++; if (scroll_speed !== 4'd8) begin n_fail++; $display("FAIL accel_sat got %0d exp 8", scroll_speed); end
        accel_is_pressed = 1'b0;
        do_frames(1);
        n_checks++; if (scroll_speed !== 4'd7) begin n_fail++; $display("FAIL decel_1 got %0d exp 7", scroll_speed); end
        do_frames(1);
        n_checks++; if (scroll_speed !== 4'd6) begin n_fail++; $display("FAIL decel_2 got %0d exp 6", scroll_speed); end
        do_frames(7);
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL decel_floor got %0d exp 0", scroll_speed); end
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL accel_still_play got %0d exp 1", game_state); end
    endtask

    task automatic test_crash();
        accel_is_pressed = 1'b1;
        do_frames(16);
        accel_is_pressed = 1'b0;
        n_checks++; if (scroll_speed !== 4'd1) begin n_fail++; $display("FAIL precrash_speed got %0d exp 1", scroll_speed); end
        pulse_collision();
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL crash_wait_frame got %0d exp 1", game_state); end
        do_frames(1);
        n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL crash_state got %0d exp 2", game_state); end
        n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL crash_lives got %0d exp 2", lives); end
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL crash_speed got %0d exp 0", scroll_speed); end
        n_checks++; if (player_enable !== 1'b0) begin n_fail++; $display("FAIL crash_enable got %0b exp 0", player_enable); end
        do_frames(89);
        n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL crash_89 got %0d exp 2", game_state); end
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL crash_89_pulse got %0b exp 0", respawn_pulse); end
        do_frames(1);
        n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL respawn_state got %0d exp 3", game_state); end
        n_checks++; if (respawn_pulse !== 1'b1) begin n_fail++; $display("FAIL respawn_pulse got %0b exp 1", respawn_pulse); end
        @(negedge clk);
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL respawn_pulse_width got %0b exp 0", respawn_pulse); end
        do_frames(59);
        n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL respawn_59 got %0d exp 3", game_state); end
        do_frames(1);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL replay_state got %0d exp 1", game_state); end
        n_checks++; if (player_enable !== 1'b1) begin n_fail++; $display("FAIL replay_enable got %0b exp 1", player_enable); end
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL replay_pulse got %0b exp 0", respawn_pulse); end
    endtask

    task automatic test_respawn_immune();
        pulse_collision();
        do_frames(1);
        n_checks++; if (lives !== 2'd1) begin n_fail++; $display("FAIL crash2_lives got %0d exp 1", lives); end
        do_frames(90);
        n_checks++; if (game_state !== 3'd3) begin n_fail++; $display("FAIL crash2_respawn got %0d exp 3", game_state); end
        pulse_collision();
        do_frames(60);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL immune_play got %0d exp 1", game_state); end
        n_checks++; if (lives !== 2'd1) begin n_fail++; $display("FAIL immune_lives got %0d exp 1", lives); end
        do_frames(1);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL immune_no_latch got %0d exp 1", game_state); end
    endtask

    task automatic test_game_over();
        pulse_collision();
        do_frames(1);
        n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL crash3_lives got %0d exp 0", lives); end
        do_frames(90);
        n_checks++; if (game_state !== 3'd4) begin n_fail++; $display("FAIL over_state got %0d exp 4", game_state); end
        n_checks++; if (respawn_pulse !== 1'b0) begin n_fail++; $display("FAIL over_pulse got %0b exp 0", respawn_pulse); end
        accel_is_pressed = 1'b1;
        do_frames(20);
        accel_is_pressed = 1'b0;
        n_checks++; if (game_state !== 3'd4) begin n_fail++; $display("FAIL over_frozen got %0d exp 4", game_state); end
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL over_speed got %0d exp 0", scroll_speed); end
        start_is_pressed = 1'b1;
        do_frames(1);
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL over_to_idle got %0d exp 0", game_state); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL idle_lives got %0d exp 3", lives); end
        do_frames(3);
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL held_start got %0d exp 0", game_state); end
        start_is_pressed = 1'b0;
        do_frames(1);
        start_is_pressed = 1'b1;
        do_frames(1);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL repress_play got %0d exp 1", game_state); end
        n_checks++; if (respawn_pulse !== 1'b1) begin n_fail++; $display("FAIL repress_pulse got %0b exp 1", respawn_pulse); end
        start_is_pressed = 1'b0;
        do_frames(1);
    endtask

    task automatic test_fuel();
        accel_is_pressed = 1'b1;
        do_frames(16);
        n_checks++; if (scroll_speed !== 4'd1) begin n_fail++; $display("FAIL prefuel_speed got %0d exp 1", scroll_speed); end
        @(negedge clk);
        frame_start = 1'b1;
        collision   = 1'b1;
        fuel_empty  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        collision   = 1'b0;
        fuel_empty  = 1'b0;
        accel_is_pressed = 1'b0;
        n_checks++; if (game_state !== 3'd4) begin n_fail++; $display("FAIL fuel_state got %0d exp 4", game_state); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL fuel_lives got %0d exp 3", lives); end
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL fuel_speed got %0d exp 0", scroll_speed); end
    endtask

    task automatic test_reset_mid_crash();
        start_is_pressed = 1'b1;
        do_frames(1);
        start_is_pressed = 1'b0;
        do_frames(1);
        start_is_pressed = 1'b1;
        do_frames(1);
        start_is_pressed = 1'b0;
        do_frames(1);
        n_checks++; if (game_state !== 3'd1) begin n_fail++; $display("FAIL rearm_play got %0d exp 1", game_state); end
        pulse_collision();
        do_frames(11);
        n_checks++; if (game_state !== 3'd2) begin n_fail++; $display("FAIL midcrash_state got %0d exp 2", game_state); end
        n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL midcrash_lives got %0d exp 2", lives); end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL async_state got %0d exp 0", game_state); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL async_lives got %0d exp 3", lives); end
        n_checks++; if (scroll_speed !== 4'd0) begin n_fail++; $display("FAIL async_speed got %0d exp 0", scroll_speed); end
        @(negedge clk);
        resetN = 1'b1;
        do_frames(5);
        n_checks++; if (game_state !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle got %0d exp 0", game_state); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN           = 1'b0;
        frame_start      = 1'b0;
        start_is_pressed = 1'b0;
        accel_is_pressed = 1'b0;
        collision        = 1'b0;
        fuel_empty       = 1'b0;
        test_reset();
        test_start();
        test_accel();
        test_crash();
        test_respawn_immune();
        test_game_over();
        test_fuel();
        test_reset_mid_crash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
